// File: rtl/nn_serial_pkg.sv
// Shared types and default frame geometry for the serial input path.
// Used by the frame controller and the CLOCK_50-side shift register/push logic.
package nn_serial_pkg;

    localparam int NN_NUM_INPUTS = 784;
    localparam int NN_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        WAIT_ACK
    } serial_state_t;

    // Counter width that is never zero, so degenerate sizes still elaborate.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/serial_frame_controller_sync.sv
// Two-flop synchronizer for a toggle crossing into the local clock domain.
// Asynchronous active-high reset clears both stages.
module toggle_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/serial_frame_controller.sv
// Serial-clock frame sequencer: bit/word counting, frame-ready toggle, ack handshake.
// Optional per-word even parity slot enabled with `define SERIAL_WORD_PARITY_EN.
module serial_frame_controller
    import nn_serial_pkg::*;
#(
    parameter int numInputs = NN_NUM_INPUTS,
    parameter int dataWidth = NN_DATA_WIDTH
) (
    input  logic                           serialClock,
    input  logic                           reset,
    input  logic                           frameSelect,
    input  logic                           serialData,
    input  logic                           pushAckToggle,
    input  logic                           clearErr,
    output logic                           shiftEn,
    output logic [$clog2(numInputs+1)-1:0] wordCount,
    output logic [$clog2(dataWidth)-1:0]   bitCount,
    output logic                           frameReadyToggle,
    output logic                           busy,
    output logic                           shortFrameErr,
    output logic                           overrunErr,
    output logic                           parityErr
);

    localparam int WC_W = $clog2(numInputs + 1);
    localparam int BC_W = $clog2(dataWidth);

`ifdef SERIAL_WORD_PARITY_EN
    // One extra internal count value marks the parity slot.
    localparam int BI_W = cnt_width(dataWidth);
    localparam bit PAR_EN = 1'b1;
`else
    localparam int BI_W = BC_W;
    localparam bit PAR_EN = 1'b0;
`endif

    localparam logic [BI_W-1:0] LAST_BIT  = BI_W'(dataWidth - 1);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(numInputs - 1);

    serial_state_t   state_q, state_d;
    logic [WC_W-1:0] word_q, word_d;
    logic [BI_W-1:0] bit_q, bit_d;
    logic            tog_q, tog_d;
    logic            short_q, short_d;
    logic            over_q, over_d;
    logic            ack_sync;
    logic            par_slot;
    logic            word_end;
    logic            short_set;
    logic            over_set;

`ifdef SERIAL_WORD_PARITY_EN
    logic par_acc_q, par_acc_d;
    logic par_err_q, par_err_d;
    logic par_set;
`endif

    toggle_sync2 u_ack_sync (
        .clk   (serialClock),
        .reset (reset),
        .din   (pushAckToggle),
        .dout  (ack_sync)
    );

`ifdef SERIAL_WORD_PARITY_EN
    assign par_slot = (state_q == RECEIVE) && (bit_q == BI_W'(dataWidth));
`else
    assign par_slot = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        bit_d     = bit_q;
        tog_d     = tog_q;
        word_end  = 1'b0;
        short_set = 1'b0;
        over_set  = 1'b0;
`ifdef SERIAL_WORD_PARITY_EN
        par_acc_d = par_acc_q;
        par_set   = 1'b0;
`endif
        unique case (state_q)
            IDLE, RECEIVE: begin
                if (frameSelect) begin
                    state_d = RECEIVE;
                    if (par_slot) begin
`ifdef SERIAL_WORD_PARITY_EN
                        par_set = par_acc_q ^ serialData;
`endif
                        word_end = 1'b1;
                    end else begin
`ifdef SERIAL_WORD_PARITY_EN
                        par_acc_d = ((bit_q == '0) ? 1'b0 : par_acc_q) ^ serialData;
`endif
                        if (!PAR_EN && (bit_q == LAST_BIT)) begin
                            word_end = 1'b1;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                    if (word_end) begin
                        bit_d = '0;
                        if (word_q == LAST_WORD) begin
                            word_d  = '0;
                            tog_d   = ~tog_q;
                            state_d = WAIT_ACK;
                        end else begin
                            word_d = word_q + 1'b1;
                        end
                    end
                end else if (state_q == RECEIVE) begin
                    // Window closed early: drop the partial frame.
                    short_set = 1'b1;
                    word_d    = '0;
                    bit_d     = '0;
                    state_d   = IDLE;
                end
            end
            WAIT_ACK: begin
                over_set = frameSelect;
                if (ack_sync == tog_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                word_d  = '0;
                bit_d   = '0;
            end
        endcase

        short_d = short_set ? 1'b1 : (clearErr ? 1'b0 : short_q);
        over_d  = over_set  ? 1'b1 : (clearErr ? 1'b0 : over_q);
`ifdef SERIAL_WORD_PARITY_EN
        par_err_d = par_set ? 1'b1 : (clearErr ? 1'b0 : par_err_q);
`endif
    end

    always_ff @(posedge serialClock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            bit_q   <= '0;
            tog_q   <= 1'b0;
            short_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            tog_q   <= tog_d;
            short_q <= short_d;
            over_q  <= over_d;
        end
    end

`ifdef SERIAL_WORD_PARITY_EN
    always_ff @(posedge serialClock or posedge reset) begin
        if (reset) begin
            par_acc_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_acc_q <= par_acc_d;
            par_err_q <= par_err_d;
        end
    end

    assign parityErr = par_err_q;
`else
    assign parityErr = 1'b0;
`endif

    assign shiftEn          = frameSelect && (state_q != WAIT_ACK) && !par_slot;
    assign wordCount        = word_q;
    assign bitCount         = BC_W'(bit_q);
    assign frameReadyToggle = tog_q;
    assign busy             = (state_q != IDLE);
    assign shortFrameErr    = short_q;
    assign overrunErr       = over_q;

endmodule

// File: tb/tb_serial_frame_controller.sv
// Directed bench for serial_frame_controller with numInputs=4, dataWidth=4.
// Build with SERIAL_WORD_PARITY_EN defined to exercise the parity slot.
module tb_serial_frame_controller;

    localparam int NI = 4;
    localparam int DW = 4;
`ifdef SERIAL_WORD_PARITY_EN
    localparam int SPW = DW + 1;
`else
    localparam int SPW = DW;
`endif
    localparam int SLOTS = NI * SPW;

    logic       serialClock = 1'b0;
    logic       reset = 1'b1;
    logic       frameSelect = 1'b0;
    logic       serialData = 1'b0;
    logic       pushAckToggle = 1'b0;
    logic       clearErr = 1'b0;
    logic       shiftEn;
    logic [2:0] wordCount;
    logic [1:0] bitCount;
    logic       frameReadyToggle;
    logic       busy;
    logic       shortFrameErr;
    logic       overrunErr;
    logic       parityErr;

    int   checks = 0;
    int   failures = 0;
    int   ens;
    logic se_last;
    logic sd;
    logic [3:0] words [4] = '{4'hA, 4'h5, 4'h3, 4'hC};

    serial_frame_controller #(
        .numInputs (NI),
        .dataWidth (DW)
    ) dut (
        .serialClock      (serialClock),
        .reset            (reset),
        .frameSelect      (frameSelect),
        .serialData       (serialData),
        .pushAckToggle    (pushAckToggle),
        .clearErr         (clearErr),
        .shiftEn          (shiftEn),
        .wordCount        (wordCount),
        .bitCount         (bitCount),
        .frameReadyToggle (frameReadyToggle),
        .busy             (busy),
        .shortFrameErr    (shortFrameErr),
        .overrunErr       (overrunErr),
        .parityErr        (parityErr)
    );

    always #5 serialClock = ~serialClock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bit slot, sample shiftEn before the edge, settle after it.
    task automatic tick(input logic fs, input logic d);
        frameSelect = fs;
        serialData  = d;
        #1;
        se_last = shiftEn;
        @(posedge serialClock);
        #1;
    endtask

    // Serial value for slot s of a frame; parity slot inverted on bad_word.
    function automatic logic slot_bit(input int s, input int bad_word);
        int w;
        int b;
        logic [3:0] wv;
        w  = s / SPW;
        b  = s % SPW;
        wv = words[w];
        if (b < DW) return wv[DW-1-b];
        return (^wv) ^ (w == bad_word);
    endfunction

    task automatic send_frame(input int bad_word, output int n_en);
        n_en = 0;
        for (int s = 0; s < SLOTS; s++) begin
            tick(1'b1, slot_bit(s, bad_word));
            if (se_last) n_en++;
        end
        frameSelect = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_tog", frameReadyToggle, 1'b0);
        check("rst_wc", wordCount, 3'd0);
        check("rst_bc", bitCount, 2'd0);
        check("rst_short", shortFrameErr, 1'b0);
        check("rst_over", overrunErr, 1'b0);
        check("rst_par", parityErr, 1'b0);
        #6;
        reset = 1'b0;
        @(posedge serialClock);
        #1;

        // Full frame, then ack
        ens = 0;
        for (int s = 0; s < SLOTS; s++) begin
            tick(1'b1, slot_bit(s, -1));
            if (se_last) ens++;
            if (s == 0) begin
                check("f1_bc_after_first", bitCount, 2'd1);
                check("f1_busy_first", busy, 1'b1);
            end
            if (s == SPW) check("f1_wc_word1", wordCount, 3'd1);
        end
        check("f1_shift_count", ens, 16);
        check("f1_toggle", frameReadyToggle, 1'b1);
        check("f1_busy_wait", busy, 1'b1);
        check("f1_wc_clear", wordCount, 3'd0);
        check("f1_bc_clear", bitCount, 2'd0);
        pushAckToggle = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("f1_busy_pre_ack", busy, 1'b1);
        tick(1'b0, 1'b0);
        check("f1_busy_ack", busy, 1'b0);
        check("f1_short", shortFrameErr, 1'b0);
        check("f1_over", overrunErr, 1'b0);
        check("f1_par", parityErr, 1'b0);

        // Short frame after 9 bits
        for (int s = 0; s < 9; s++) tick(1'b1, slot_bit(s, -1));
        check("sh_busy_mid", busy, 1'b1);
        tick(1'b0, 1'b0);
        check("sh_err", shortFrameErr, 1'b1);
        check("sh_wc", wordCount, 3'd0);
        check("sh_bc", bitCount, 2'd0);
        check("sh_idle", busy, 1'b0);
        check("sh_tog", frameReadyToggle, 1'b1);
        clearErr = 1'b1;
        tick(1'b0, 1'b0);
        clearErr = 1'b0;
        check("sh_clear", shortFrameErr, 1'b0);

        // Overrun: second frame before ack
        send_frame(-1, ens);
        check("ov_frame_tog", frameReadyToggle, 1'b0);
        ens = 0;
        for (int s = 0; s < 8; s++) begin
            tick(1'b1, 1'b1);
            if (se_last) ens++;
        end
        check("ov_shift_none", ens, 0);
        check("ov_err", overrunErr, 1'b1);
        check("ov_tog_hold", frameReadyToggle, 1'b0);
        check("ov_busy", busy, 1'b1);
        clearErr = 1'b1;
        tick(1'b1, 1'b0);
        check("ov_clr_vs_set", overrunErr, 1'b1);
        tick(1'b0, 1'b0);
        clearErr = 1'b0;
        check("ov_clr_alone", overrunErr, 1'b0);
        pushAckToggle = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("ov_busy_ack", busy, 1'b0);

        // Reset mid-frame, then a clean frame
        for (int s = 0; s < 10; s++) tick(1'b1, slot_bit(s, -1));
        check("rm_busy_pre", busy, 1'b1);
        frameSelect = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rm_busy", busy, 1'b0);
        check("rm_wc", wordCount, 3'd0);
        check("rm_bc", bitCount, 2'd0);
        check("rm_tog", frameReadyToggle, 1'b0);
        check("rm_shift", shiftEn, 1'b0);
        #2;
        reset = 1'b0;
        @(posedge serialClock);
        #1;
        send_frame(-1, ens);
        check("rm_frame_shift", ens, 16);
        check("rm_frame_tog", frameReadyToggle, 1'b1);
        pushAckToggle = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("rm_busy_ack", busy, 1'b0);

`ifdef SERIAL_WORD_PARITY_EN
        // Bad parity on word 2
        ens = 0;
        for (int s = 0; s < SLOTS; s++) begin
            tick(1'b1, slot_bit(s, 2));
            if (se_last) ens++;
            if (s % SPW == DW) check($sformatf("pa_slot%0d_shift", s + 1), se_last, 1'b0);
            if (s == 9) check("pa_err_before", parityErr, 1'b0);
            if (s == 14) check("pa_err_word2", parityErr, 1'b1);
        end
        frameSelect = 1'b0;
        check("pa_shift_count", ens, 16);
        check("pa_err_end", parityErr, 1'b1);
        check("pa_tog", frameReadyToggle, 1'b0);
        pushAckToggle = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("pa_busy_ack", busy, 1'b0);
`else
        check("np_par_tied", parityErr, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_frame_controller.md
# serial_frame_controller

Sequencer for the serial input path of the network. Runs in the `serialClock` domain and counts words and bits of an incoming image frame. It produces the per-bit shift enable for the input shift register and a frame-ready toggle that the CLOCK_50 side turns into its buffer-push pulse. It then holds off further input until the CLOCK_50 side acknowledges capture, and flags malformed or overrunning frames.

## Interface
- `numInputs`, default 784: words per frame.
- `dataWidth`, default 16: bits per word, MSB first.
- `serialClock`  in  1  serial bit clock; every edge with `frameSelect`=1 is one bit slot.
- `reset`  in  1  asynchronous, active-high; clock `serialClock`.
- `frameSelect`  in  1  host frame window; high for the whole frame.
- `serialData`  in  1  serial bit; used only for the parity check.
- `pushAckToggle`  in  1  from CLOCK_50 domain; toggles once per captured frame.
- `clearErr`  in  1  synchronous clear of sticky error flags.
- `shiftEn`  out  1  combinational; the shift register shifts on this edge when 1.
- `wordCount`  out  $clog2(numInputs+1)  words completed in the current frame.
- `bitCount`  out  $clog2(dataWidth)  bit index within the current word.
- `frameReadyToggle`  out  1  flips once per complete frame.
- `busy`  out  1  high in RECEIVE or WAIT_ACK.
- `shortFrameErr`, `overrunErr`, `parityErr`  out  1 each  sticky error flags.

## Operation
- States: IDLE, RECEIVE, WAIT_ACK.
- IDLE:
  - `frameSelect`=1 on an edge counts as bit 0 of word 0.
  - State moves to RECEIVE and `bitCount` becomes 1.
- RECEIVE:
  - Each edge with `frameSelect`=1 accepts one bit.
  - `bitCount` wraps from dataWidth-1 to 0 and increments `wordCount`.
- Frame complete:
  - Occurs when bit dataWidth-1 of word numInputs-1 is accepted.
  - On that same edge: `frameReadyToggle` flips, counters clear, state moves to WAIT_ACK.
- `frameSelect`=0 mid-frame (RECEIVE with a nonzero count):
  - Sets `shortFrameErr`, clears counters, returns to IDLE.
  - No toggle is produced; the partial frame is discarded.
- WAIT_ACK:
  - `shiftEn`=0.
  - Any edge with `frameSelect`=1 sets `overrunErr`; the bit is dropped.
  - `pushAckToggle` passes through a 2-FF synchronizer on `serialClock`.
  - When the synchronized ack equals `frameReadyToggle`, state moves to IDLE.
  - If `frameSelect`=1 on that same edge, the bit is still dropped and flagged.
- `shiftEn` = `frameSelect` AND (state ≠ WAIT_ACK) AND (not a parity slot).
- `clearErr` has priority below set: if `clearErr` and a set event occur on the same edge, the flag stays 1.
- Counter widths must hold numInputs and dataWidth-1 exactly; no saturation is needed because the frame-complete event resets both counters.

## Timing
- Reset asserted (asynchronous): state IDLE, all counters 0, `frameReadyToggle`=0, `busy`=0, all error flags 0, ack synchronizer 0.
- Reset mid-frame or mid-WAIT_ACK abandons the frame; no toggle is issued.
- Latency from the last data bit edge to the `frameReadyToggle` flip is 0 edges (registered on that edge).
- The ack needs 2 `serialClock` edges after it is stable to be seen. The host must supply at least 3 edges with `frameSelect`=0 after each frame; the bit clock must not stop while in WAIT_ACK.
- `frameSelect` and `serialData` are sampled on the rising edge of `serialClock`.

## Configuration
- `SERIAL_WORD_PARITY_EN` defined:
  - Each word is followed by one even-parity bit, so a frame is numInputs×(dataWidth+1) slots.
  - During the parity slot `shiftEn`=0 and `bitCount`=dataWidth is held internally (the extra bit state is internal).
  - On a mismatch `parityErr` is set; the frame still completes.
- Not defined:
  - No parity slot; a frame is numInputs×dataWidth bits.
  - `parityErr` is tied to 0.

## Structure
- The shared package `nn_serial_pkg` holds:
  - the state enum `serial_state_t` (IDLE, RECEIVE, WAIT_ACK);
  - the default numInputs/dataWidth constants shared with the shift register.
- One sub-module: `toggle_sync2`, the 2-FF synchronizer with asynchronous reset, reused by the CLOCK_50-side push generator.

## Test plan
All scenarios use numInputs=4, dataWidth=4.
- 16 bits with `frameSelect`=1, then 3 idle edges with ack toggled: `shiftEn` high for exactly 16 edges, `frameReadyToggle` 0→1 on edge 16, `busy` falls after ack sync, no errors.
- `frameSelect` dropped after 9 bits: `shortFrameErr`=1, `wordCount`=0, no toggle, state IDLE.
- A second frame started before the ack: `shiftEn`=0 for all of its bits, `overrunErr`=1, `frameReadyToggle` unchanged.
- Reset asserted after 10 bits: all outputs 0 immediately; a following full frame completes normally with the toggle going 0→1.
- `clearErr` on the same edge as a new overrun: `overrunErr` stays 1; `clearErr` alone next edge → 0.
- With `SERIAL_WORD_PARITY_EN`, 20 slots with a bad parity bit on word 2: `shiftEn` low on slots 5, 10, 15, 20; `parityErr`=1; the toggle still flips on slot 20.
